logo_motion_ctrl: RTL and testbench
===================================

# logo_motion_ctrl

Frame-synchronous motion controller for the bouncing-logo VGA demo. Once per frame, or once every N frames, it computes the next logo position from a programmable speed and reflects the motion at the display edges. It publishes `logo_left`/`logo_top` to the pixel datapath, together with direction, palette index and bounce/corner event pulses. It sits between the VGA sync generator (which supplies `frame_tick`) and the logo renderer / bitmap ROM stage.

## Interface

Parameters:
- `LOGO_SIZE`, 128: logo edge length in pixels.
- `DISPLAY_WIDTH`, 640: visible width.
- `DISPLAY_HEIGHT`, 480: visible height.
- `INIT_X`, 200: `logo_left` after reset.
- `INIT_Y`, 200: `logo_top` after reset.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: pixel clock.
- `reset` in 1: synchronous, active-high.
- `frame_tick` in 1: one-cycle pulse at frame start.
- `pause` in 1: while high, ticks are ignored.
- `speed` in 3: step size = `speed`+1 pixels per move.
- `frame_div` in 4: move once every `frame_div`+1 ticks.
- `logo_left` out 10: logo X origin.
- `logo_top` out 10: logo Y origin.
- `dir_x` out 1: 1 = moving right.
- `dir_y` out 1: 1 = moving down.
- `color_idx` out 3: palette index, advanced on bounce.
- `bounce_pulse` out 1: one cycle, any edge hit this move.
- `corner_pulse` out 1: one cycle, X and Y edges hit in the same move.
- `busy` out 1: update sequence in progress.

## Operation

- Limits: MAX_X = `DISPLAY_WIDTH`−`LOGO_SIZE` (512), MAX_Y = `DISPLAY_HEIGHT`−`LOGO_SIZE` (352). The minimum on both axes is 0.
- FSM states: IDLE → CALC_X → CALC_Y → COMMIT → IDLE.
- **IDLE**
  - `frame_tick` with `pause`=0 advances the divider counter `div_cnt`.
  - If `div_cnt` ≥ `frame_div` (the ≥ covers `frame_div` being lowered mid-count): clear `div_cnt`, latch `speed`, go to CALC_X.
  - Otherwise increment `div_cnt` and stay in IDLE.
- **CALC_X**: the shared axis stepper computes `nx`/`ndx`/`hx` from `logo_left`, `dir_x`, MAX_X. Results go into shadow registers.
- **CALC_Y**: the same stepper computes `ny`/`ndy`/`hy` from `logo_top`, `dir_y`, MAX_Y.
- **COMMIT**
  - Load `logo_left`, `logo_top`, `dir_x`, `dir_y` from the shadows in the same cycle, so positions always update atomically.
  - `bounce_pulse` = `hx`|`hy`; `corner_pulse` = `hx`&`hy`.
  - `color_idx` += 1 (mod 8) when `hx`|`hy`. The increment is a single step even on a corner hit.
- Axis step rule (11-bit intermediate, s = step):
  - dir=1: if pos+s ≥ MAX → pos=MAX, dir=0, hit=1; else pos+s.
  - dir=0: if pos ≤ s → pos=0, dir=1, hit=1; else pos−s.
  - Landing exactly on a limit counts as a hit and reverses direction.
- Boundary and concurrency rules:
  - `frame_tick` while `busy`: ignored; `div_cnt` unchanged.
  - `pause` high: ticks ignored and `div_cnt` held. A sequence already past IDLE still completes.
  - `reset` mid-sequence: immediate return to reset values. No commit and no pulse.
- Reset values:
  - `logo_left`=`INIT_X`, `logo_top`=`INIT_Y`.
  - `dir_x`=1, `dir_y`=0.
  - `color_idx`=0.
  - `bounce_pulse`=`corner_pulse`=`busy`=0.
  - State IDLE, `div_cnt`=0.

## Timing

- Accepted tick sampled at edge E0. CALC_X is evaluated at edge E1, CALC_Y at E2, and outputs update at E3.
- Latency is therefore 3 clocks from the accepted tick to the new position.
- `busy` is high from after E0 until E3; it is low in the cycle after COMMIT.
- `bounce_pulse`/`corner_pulse` are high exactly one cycle, the cycle after E3.
- All outputs are registered. No combinational path from inputs to outputs.
- Maximum accepted tick rate: one every 4 clocks, far above frame rate.

## Structure

- Shared package `dvd_pkg`:
  - Constants `LOGO_SIZE`, `DISPLAY_WIDTH`, `DISPLAY_HEIGHT`, `MAX_X`, `MAX_Y`.
  - State enum `motion_state_t` {IDLE, CALC_X, CALC_Y, COMMIT}.
- One sub-module, `axis_stepper`: a purely combinational step/reflect unit (pos, dir, step, max → new pos, new dir, hit). It is instantiated once and time-shared across CALC_X/CALC_Y via an input mux. This is the reason the update is sequenced rather than parallel.

## Test plan

- Reset, `speed`=0, `frame_div`=0, one tick → 3 clocks later `logo_left`=201, `logo_top`=199, `busy` low, no pulse.
- `INIT_X`=510, `speed`=3, tick → `logo_left`=512, `dir_x`=0, `bounce_pulse` one cycle, `color_idx`=1, `corner_pulse`=0.
- `INIT_X`=511, `INIT_Y`=1, `speed`=0, tick → `logo_left`=512, `logo_top`=0, `dir_x`=0, `dir_y`=1, `bounce_pulse`=`corner_pulse`=1 for one cycle, `color_idx`=1.
- `frame_div`=2, six ticks spaced 10 clocks → position changes only after ticks 3 and 6. With `pause` high for ticks 7–9 → no change and `div_cnt` held.
- Tick, then a second tick 1 clock later (during `busy`) → exactly one move of 1 pixel per axis.
- Tick, then `reset` asserted in the CALC_Y cycle → outputs at `INIT_X`/`INIT_Y`, `dir_x`=1, `dir_y`=0, no `bounce_pulse`, state IDLE.

Source files
------------

// File: rtl/dvd_pkg.sv
// Shared constants and state type for the bouncing-logo motion controller.
package dvd_pkg;

  localparam int LOGO_SIZE      = 128;
  localparam int DISPLAY_WIDTH  = 640;
  localparam int DISPLAY_HEIGHT = 480;
  localparam int MAX_X          = DISPLAY_WIDTH - LOGO_SIZE;
  localparam int MAX_Y          = DISPLAY_HEIGHT - LOGO_SIZE;

  typedef enum logic [1:0] {
    IDLE,
    CALC_X,
    CALC_Y,
    COMMIT
  } motion_state_t;

  // A speed code of n moves the logo n+1 pixels per update.
  function automatic logic [10:0] step_of(input logic [2:0] speed);
    return {8'd0, speed} + 11'd1;
  endfunction

endpackage

// File: rtl/axis_stepper.sv
// Combinational single-axis step with reflection at 0 and max_pos.
module axis_stepper (
  input  logic [9:0]  pos,
  input  logic        dir,
  input  logic [10:0] step,
  input  logic [10:0] max_pos,
  output logic [9:0]  new_pos,
  output logic        new_dir,
  output logic        hit
);

  logic [10:0] sum;
  logic [10:0] diff;

  // Landing exactly on a limit counts as a hit and reverses direction.
  always_comb begin
    sum     = {1'b0, pos} + step;
    diff    = {1'b0, pos} - step;
    new_pos = pos;
    new_dir = dir;
    hit     = 1'b0;
    if (dir) begin
      if (sum >= max_pos) begin
        new_pos = max_pos[9:0];
        new_dir = 1'b0;
        hit     = 1'b1;
      end else begin
        new_pos = sum[9:0];
      end
    end else begin
      if ({1'b0, pos} <= step) begin
        new_pos = 10'd0;
        new_dir = 1'b1;
        hit     = 1'b1;
      end else begin
        new_pos = diff[9:0];
      end
    end
  end

endmodule

// File: rtl/logo_motion_ctrl.sv
// Frame-synchronous logo motion controller: one shared axis stepper,
// sequenced X then Y, with an atomic commit of both axes.
module logo_motion_ctrl #(
  parameter int LOGO_SIZE      = 128,
  parameter int DISPLAY_WIDTH  = 640,
  parameter int DISPLAY_HEIGHT = 480,
  parameter int INIT_X         = 200,
  parameter int INIT_Y         = 200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       pause,
  input  logic [2:0] speed,
  input  logic [3:0] frame_div,
  output logic [9:0] logo_left,
  output logic [9:0] logo_top,
  output logic       dir_x,
  output logic       dir_y,
  output logic [2:0] color_idx,
  output logic       bounce_pulse,
  output logic       corner_pulse,
  output logic       busy
);

  import dvd_pkg::*;

  localparam logic [10:0] LIM_X  = 11'(DISPLAY_WIDTH - LOGO_SIZE);
  localparam logic [10:0] LIM_Y  = 11'(DISPLAY_HEIGHT - LOGO_SIZE);
  localparam logic [9:0]  START_X = 10'(INIT_X);
  localparam logic [9:0]  START_Y = 10'(INIT_Y);

  motion_state_t state;
  logic [3:0]    div_cnt;
  logic [2:0]    speed_r;

  logic [9:0]    nx, ny;
  logic          ndx, ndy;
  logic          hx, hy;

  logic [9:0]    st_pos;
  logic          st_dir;
  logic [10:0]   st_max;
  logic [9:0]    st_new_pos;
  logic          st_new_dir;
  logic          st_hit;

  // The stepper serves X during CALC_X and Y during CALC_Y.
  always_comb begin
    st_pos = logo_left;
    st_dir = dir_x;
    st_max = LIM_X;
    if (state == CALC_Y) begin
      st_pos = logo_top;
      st_dir = dir_y;
      st_max = LIM_Y;
    end
  end

  axis_stepper u_stepper (
    .pos     (st_pos),
    .dir     (st_dir),
    .step    (step_of(speed_r)),
    .max_pos (st_max),
    .new_pos (st_new_pos),
    .new_dir (st_new_dir),
    .hit     (st_hit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      div_cnt      <= 4'd0;
      speed_r      <= 3'd0;
      nx           <= 10'd0;
      ny           <= 10'd0;
      ndx          <= 1'b0;
      ndy          <= 1'b0;
      hx           <= 1'b0;
      hy           <= 1'b0;
      logo_left    <= START_X;
      logo_top     <= START_Y;
      dir_x        <= 1'b1;
      dir_y        <= 1'b0;
      color_idx    <= 3'd0;
      bounce_pulse <= 1'b0;
      corner_pulse <= 1'b0;
      busy         <= 1'b0;
    end else begin
      bounce_pulse <= 1'b0;
      corner_pulse <= 1'b0;
      case (state)
        IDLE: begin
          // The >= lets a frame_div lowered mid-count take effect at once.
          if (frame_tick && !pause) begin
            if (div_cnt >= frame_div) begin
              div_cnt <= 4'd0;
              speed_r <= speed;
              busy    <= 1'b1;
              state   <= CALC_X;
            end else begin
              div_cnt <= div_cnt + 4'd1;
            end
          end
        end
        CALC_X: begin
          nx    <= st_new_pos;
          ndx   <= st_new_dir;
          hx    <= st_hit;
          state <= CALC_Y;
        end
        CALC_Y: begin
          ny    <= st_new_pos;
          ndy   <= st_new_dir;
          hy    <= st_hit;
          state <= COMMIT;
        end
        COMMIT: begin
          logo_left    <= nx;
          logo_top     <= ny;
          dir_x        <= ndx;
          dir_y        <= ndy;
          bounce_pulse <= hx | hy;
          corner_pulse <= hx & hy;
          if (hx | hy) begin
            color_idx <= color_idx + 3'd1;
          end
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_logo_motion_ctrl.sv
// Scoreboard bench for logo_motion_ctrl: three instances with different start points share one stimulus stream.
module tb_logo_motion_ctrl;

  typedef struct {
    logic [9:0] l;
    logic [9:0] t;
    logic       dx;
    logic       dy;
    logic [2:0] c;
    logic       b;
    logic       k;
  } exp_t;

  localparam int IX[3] = '{200, 510, 511};
  localparam int IY[3] = '{200, 200, 1};
  localparam int LX = 512;
  localparam int LY = 352;

  logic       clk;
  logic       reset;
  logic       frame_tick;
  logic       pause;
  logic [2:0] speed;
  logic [3:0] frame_div;

  logic [9:0] left_o[3];
  logic [9:0] top_o[3];
  logic       dx_o[3];
  logic       dy_o[3];
  logic [2:0] col_o[3];
  logic       bnc_o[3];
  logic       cor_o[3];
  logic       busy_o[3];

  exp_t sb[$];
  int   total;
  int   bad;

  int mx[3], my[3], mdx[3], mdy[3], mc[3];
  int div_model;

  logo_motion_ctrl #(.INIT_X(200), .INIT_Y(200)) u0 (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .pause(pause),
    .speed(speed), .frame_div(frame_div),
    .logo_left(left_o[0]), .logo_top(top_o[0]), .dir_x(dx_o[0]), .dir_y(dy_o[0]),
    .color_idx(col_o[0]), .bounce_pulse(bnc_o[0]), .corner_pulse(cor_o[0]), .busy(busy_o[0])
  );

  logo_motion_ctrl #(.INIT_X(510), .INIT_Y(200)) u1 (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .pause(pause),
    .speed(speed), .frame_div(frame_div),
    .logo_left(left_o[1]), .logo_top(top_o[1]), .dir_x(dx_o[1]), .dir_y(dy_o[1]),
    .color_idx(col_o[1]), .bounce_pulse(bnc_o[1]), .corner_pulse(cor_o[1]), .busy(busy_o[1])
  );

  logo_motion_ctrl #(.INIT_X(511), .INIT_Y(1)) u2 (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .pause(pause),
    .speed(speed), .frame_div(frame_div),
    .logo_left(left_o[2]), .logo_top(top_o[2]), .dir_x(dx_o[2]), .dir_y(dy_o[2]),
    .color_idx(col_o[2]), .bounce_pulse(bnc_o[2]), .corner_pulse(cor_o[2]), .busy(busy_o[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic chk(input string tag, input int idx, input logic [15:0] obs, input logic [15:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s[%0d] observed=%0d expected=%0d", tag, idx, obs, expv);
    end
  endtask

  function automatic void axis(input int pos, input int dir, input int s, input int lim,
                               output int np, output int nd, output int h);
    np = pos; nd = dir; h = 0;
    if (dir == 1) begin
      if (pos + s >= lim) begin np = lim; nd = 0; h = 1; end
      else np = pos + s;
    end else begin
      if (pos <= s) begin np = 0; nd = 1; h = 1; end
      else np = pos - s;
    end
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mx[i] = IX[i]; my[i] = IY[i]; mdx[i] = 1; mdy[i] = 0; mc[i] = 0;
    end
    div_model = 0;
  endtask

  // Pushes one expectation per instance, stepping the model when the tick moves the logo.
  task automatic push_expected(input bit moved);
    exp_t e;
    int nx, ndx, hx, ny, ndy, hy, s;
    s = int'(speed) + 1;
    for (int i = 0; i < 3; i++) begin
      hx = 0; hy = 0;
      if (moved) begin
        axis(mx[i], mdx[i], s, LX, nx, ndx, hx);
        axis(my[i], mdy[i], s, LY, ny, ndy, hy);
        mx[i] = nx; mdx[i] = ndx; my[i] = ny; mdy[i] = ndy;
        if (hx == 1 || hy == 1) mc[i] = (mc[i] + 1) % 8;
      end
      e.l  = 10'(mx[i]);
      e.t  = 10'(my[i]);
      e.dx = mdx[i][0];
      e.dy = mdy[i][0];
      e.c  = 3'(mc[i]);
      e.b  = (hx == 1 || hy == 1);
      e.k  = (hx == 1 && hy == 1);
      sb.push_back(e);
    end
  endtask

  task automatic check_output();
    exp_t e;
    int guard;
    guard = 0;
    while (busy_o[0] !== 1'b0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("busy_done", 0, 16'(busy_o[0]), 16'd0);
    for (int i = 0; i < 3; i++) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $error("[TB] FAIL scoreboard_empty[%0d] observed=0 expected=1", i);
      end else begin
        e = sb.pop_front();
        chk("left",   i, 16'(left_o[i]), 16'(e.l));
        chk("top",    i, 16'(top_o[i]),  16'(e.t));
        chk("dir_x",  i, 16'(dx_o[i]),   16'(e.dx));
        chk("dir_y",  i, 16'(dy_o[i]),   16'(e.dy));
        chk("color",  i, 16'(col_o[i]),  16'(e.c));
        chk("bounce", i, 16'(bnc_o[i]),  16'(e.b));
        chk("corner", i, 16'(cor_o[i]),  16'(e.k));
      end
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("bounce_off", i, 16'(bnc_o[i]), 16'd0);
      chk("corner_off", i, 16'(cor_o[i]), 16'd0);
    end
  endtask

  // One-cycle frame tick, model update, then check three clocks after the accepting edge.
  task automatic apply_stimulus();
    bit acc;
    @(negedge clk);
    frame_tick = 1'b1;
    acc = 1'b0;
    if (!pause) begin
      if (div_model >= int'(frame_div)) begin
        div_model = 0;
        acc = 1'b1;
      end else begin
        div_model++;
      end
    end
    push_expected(acc);
    @(negedge clk);
    frame_tick = 1'b0;
    chk("busy_after_tick", 0, 16'(busy_o[0]), 16'(acc));
    repeat (3) @(negedge clk);
    check_output();
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
    push_expected(1'b0);
    check_output();
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b0;
    frame_tick = 1'b0;
    pause = 1'b0;
    speed = 3'd0;
    frame_div = 4'd0;
    model_reset();

    do_reset();

    // Speed 0: plain move for u0, exact corner landing for u2.
    apply_stimulus();
    chk("tp1_left", 0, 16'(left_o[0]), 16'd201);
    chk("tp1_top",  0, 16'(top_o[0]),  16'd199);
    chk("tp3_left", 2, 16'(left_o[2]), 16'd512);
    chk("tp3_top",  2, 16'(top_o[2]),  16'd0);
    chk("tp3_dy",   2, 16'(dy_o[2]),   16'd1);
    chk("tp3_col",  2, 16'(col_o[2]),  16'd1);

    // Speed 3 from 510 clamps onto the right edge.
    do_reset();
    speed = 3'd3;
    apply_stimulus();
    chk("tp2_left", 1, 16'(left_o[1]), 16'd512);
    chk("tp2_dx",   1, 16'(dx_o[1]),   16'd0);
    chk("tp2_col",  1, 16'(col_o[1]),  16'd1);

    // Divide by three, then paused ticks must not advance the divider.
    speed = 3'd1;
    frame_div = 4'd2;
    for (int n = 0; n < 6; n++) apply_stimulus();
    pause = 1'b1;
    for (int n = 0; n < 3; n++) apply_stimulus();
    pause = 1'b0;
    for (int n = 0; n < 3; n++) apply_stimulus();

    // Lowering frame_div mid-count takes effect on the next tick.
    apply_stimulus();
    frame_div = 4'd0;
    apply_stimulus();

    // Second tick while busy is ignored.
    speed = 3'd0;
    @(negedge clk);
    frame_tick = 1'b1;
    div_model = 0;
    push_expected(1'b1);
    @(negedge clk);
    @(negedge clk);
    frame_tick = 1'b0;
    repeat (2) @(negedge clk);
    check_output();
    repeat (4) @(negedge clk);

    // Reset landing in the CALC_Y cycle aborts the move.
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    push_expected(1'b0);
    check_output();
    repeat (3) @(negedge clk);
    push_expected(1'b0);
    check_output();
    apply_stimulus();

    // Varied speeds to exercise repeated reflections.
    for (int n = 0; n < 10; n++) begin
      speed = 3'($urandom_range(0, 7));
      apply_stimulus();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
